// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer for the 5-stage pipeline: hazard stalls, redirects, debug commands, halt drain.
// Latency: enables/flush combinational from inputs; state, halted, cycle_count registered (commands act next cycle).
// Backpressure: cmd_ready low during STEP and DRAIN; a halt taken in RUN drops any same-cycle command.
module pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    input  logic             halt_op,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             redirect,
    output logic             pc_enable,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             ctrl_enable,
    output logic             stage_enable,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_RUN    = 3'b001;
    localparam logic [2:0] S_STEP   = 3'b010;
    localparam logic [2:0] S_DRAIN  = 3'b011;
    localparam logic [2:0] S_HALTED = 3'b100;

    localparam logic [1:0] C_RUN   = 2'b00;
    localparam logic [1:0] C_STEP  = 2'b01;
    localparam logic [1:0] C_PAUSE = 2'b10;
    localparam logic [1:0] C_CLEAR = 2'b11;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [2:0] state_nxt;
    logic [3:0] drain_cnt;
    logic       active;
    logic       stall;
    logic       halt_take;
    logic       cmd_acc;
    logic       cmd_eff;
    logic       clear_eff;
    logic       counting;

    assign active    = (state == S_RUN) || (state == S_STEP);
    assign stall     = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                       ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    assign halt_take = active && !stall && halt_op;
    assign cmd_ready = (state == S_IDLE) || (state == S_RUN) || (state == S_HALTED);
    assign cmd_acc   = cmd_valid && cmd_ready;
    // A halt taken this cycle swallows whatever command was accepted alongside it.
    assign cmd_eff   = cmd_acc && !halt_take;
    assign clear_eff = cmd_eff && (cmd == C_CLEAR);
    assign counting  = active || (state == S_DRAIN);
    assign halted    = (state == S_HALTED);

    always_comb begin
        pc_enable    = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        ctrl_enable  = 1'b0;
        stage_enable = 1'b0;
        if (active) begin
            if (stall || halt_op) begin
                stage_enable = 1'b1;
            end else begin
                pc_enable    = 1'b1;
                if_id_write  = 1'b1;
                ctrl_enable  = 1'b1;
                stage_enable = 1'b1;
                if_id_flush  = redirect;
            end
        end else if (state == S_DRAIN) begin
            stage_enable = 1'b1;
        end
        if (clear_eff) begin
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_eff && (cmd == C_RUN))  state_nxt = S_RUN;
                if (cmd_eff && (cmd == C_STEP)) state_nxt = S_STEP;
            end
            S_RUN: begin
                if (halt_take) begin
                    state_nxt = S_DRAIN;
                end else if (cmd_eff && ((cmd == C_PAUSE) || (cmd == C_CLEAR))) begin
                    state_nxt = S_IDLE;
                end
            end
            S_STEP:   state_nxt = halt_take ? S_DRAIN : S_IDLE;
            S_DRAIN:  if (drain_cnt == 4'd0) state_nxt = S_HALTED;
            S_HALTED: if (clear_eff) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            drain_cnt   <= 4'd0;
            cycle_count <= '0;
        end else begin
            state <= state_nxt;
            if (halt_take) begin
                drain_cnt <= DRAIN_LOAD;
            end else if ((state == S_DRAIN) && (drain_cnt != 4'd0)) begin
                drain_cnt <= drain_cnt - 4'd1;
            end
            if (clear_eff) begin
                cycle_count <= '0;
            end else if (counting && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Run/step/halt controller for the 5-stage MIPS pipeline. Sits beside the ID stage. Its job is to sequence the whole pipeline:
- drives the control-unit `enable` (deasserting it injects a bubble);
- drives the PC and IF/ID write enables, the IF/ID flush and the downstream stage-register enable;
- resolves load-use stalls and ID-resolved redirects;
- executes debug commands (RUN, STEP, PAUSE, CLEAR);
- drains in-flight instructions when a HALT opcode (6'b111111) reaches ID.

## Interface
Parameters:
- DRAIN_CYCLES, 4, cycles with only EX/MEM/WB advancing after HALT is seen in ID (range 1..15)
- CNT_W, 32, width of cycle_count

Ports (reset is asynchronous and active-low):
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  debug command valid
- cmd  in  2  command: 00 RUN, 01 STEP, 10 PAUSE, 11 CLEAR
- cmd_ready  out  1  command accepted on a rising edge where cmd_valid & cmd_ready
- halt_op  in  1  IF/ID instruction opcode == 6'b111111
- id_ex_mem_read  in  1  ID/EX holds a load
- id_ex_rt  in  5  ID/EX destination rt
- if_id_rs  in  5  IF/ID rs
- if_id_rt  in  5  IF/ID rt
- redirect  in  1  branch taken or jump resolved in ID this cycle
- pc_enable  out  1  PC write
- if_id_write  out  1  IF/ID register write
- if_id_flush  out  1  IF/ID cleared to NOP at next edge
- ctrl_enable  out  1  control-unit enable; 0 forces all control signals to 0 (bubble)
- stage_enable  out  1  ID/EX, EX/MEM, MEM/WB register and register-file write enable
- state  out  3  current FSM state
- halted  out  1  state == HALTED
- cycle_count  out  CNT_W  executed-cycle counter

## Operation
**FSM states:** IDLE=000, RUN=001, STEP=010, DRAIN=011, HALTED=100.

**Active cycle** means state is RUN or STEP.

**Load-use stall:** `stall = id_ex_mem_read & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt)`.

**Outputs in an active cycle** (combinational, evaluated in priority order):
- stall → pc_enable=0, if_id_write=0, ctrl_enable=0, stage_enable=1, if_id_flush=0. Stall beats both redirect and halt_op.
- else halt_op → pc_enable=0, if_id_write=0, ctrl_enable=0, stage_enable=1. Next state is DRAIN and the drain counter loads DRAIN_CYCLES-1.
- else redirect → all enables=1, if_id_flush=1.
- else → all enables=1, if_id_flush=0.

**Outputs in other states:**
- IDLE and HALTED: all enables=0.
- DRAIN: only stage_enable=1.

**Transitions:**
- IDLE:
  - RUN → RUN.
  - STEP → STEP.
  - PAUSE → no-op.
  - CLEAR → stays in IDLE.
- RUN:
  - PAUSE → IDLE; in-flight state is preserved.
  - CLEAR → IDLE.
  - RUN or STEP → no-op.
  - halt_op (not stalled) → DRAIN. If a command is accepted in the same cycle, halt_op wins and the command is dropped.
- STEP: lasts exactly one cycle, then → IDLE, or → DRAIN if halt_op is taken. A stalled step still consumes the step.
- DRAIN: counter decrements each cycle; on 0 → HALTED.
- HALTED: only CLEAR has effect (→ IDLE). Other commands are accepted and ignored.

**CLEAR:** when accepted, if_id_flush=1 in the accept cycle and cycle_count clears at that edge.

**cmd_ready:** 1 in IDLE, RUN and HALTED; 0 in STEP and DRAIN.

**cycle_count:** +1 per cycle in RUN, STEP or DRAIN. Saturates at all-ones. CLEAR takes precedence over the increment.

## Timing
- **Reset values:** state=IDLE, cycle_count=0, drain counter=0. All enables=0, if_id_flush=0, cmd_ready=1, halted=0.
- Reset is asynchronous mid-operation: outputs reach their reset values immediately, with no drain.
- Command latency: accepted at edge N; new state is effective from cycle N+1.
- STEP advances the pipeline exactly one edge.
- HALT in ID at cycle N (not stalled):
  - DRAIN occupies cycles N+1..N+DRAIN_CYCLES;
  - halted=1 from cycle N+DRAIN_CYCLES+1;
  - stage_enable is high for DRAIN_CYCLES+1 edges, counting the halt-detect cycle.
- Stall, redirect and flush decisions are same-cycle combinational from the inputs. The register outputs are state, cycle_count and halted.

## Test plan
- Reset, then RUN with no hazards → from the cycle after accept: state=001, all enables 1; cycle_count=10 after 10 cycles; PAUSE → state=000, enables 0, count holds at its value.
- In RUN, id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5, redirect=1 → pc_enable=0, if_id_write=0, ctrl_enable=0, if_id_flush=0, stage_enable=1. Repeat with id_ex_rt=0 → no stall, if_id_flush=1.
- In IDLE, STEP ×3 → exactly 3 cycles with pc_enable=1, each followed by a return to IDLE; cmd_ready=0 during each STEP cycle.
- In RUN, halt_op=1 (DRAIN_CYCLES=4) → 4 DRAIN cycles (only stage_enable=1), then halted=1 and state=100; RUN while halted → ignored; CLEAR → state=000, cycle_count=0, if_id_flush pulse.
- halt_op=1 and a PAUSE command in the same RUN cycle → DRAIN entered and the command dropped.
- Assert rst_n=0 mid-DRAIN and between clock edges → outputs reach their reset values immediately. Separately: force cycle_count to all-ones, run 2 cycles → count stays saturated.
